// File: rtl/bcd_calc_pkg.sv
// Shared types and constants for the 2-digit BCD add/subtract calculator.
package bcd_calc_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Entry states carry their own one-hot display code, so entry_pos is the state register itself.
  typedef enum logic [3:0] {
    A_TENS = 4'b1000,
    A_ONES = 4'b0100,
    B_TENS = 4'b0010,
    B_ONES = 4'b0001,
    DONE   = 4'b0000
  } entry_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_operand_entry_if.sv
// Board-side switch/button inputs and the operand bus toward the adder and display.
interface bcd_operand_entry_if;
  import bcd_calc_pkg::*;

  logic               KEY_ENTER_N;
  logic [DIGIT_W-1:0] digit_in;
  logic               op_in;
  logic [DIGIT_W-1:0] a_10;
  logic [DIGIT_W-1:0] a_1;
  logic [DIGIT_W-1:0] b_10;
  logic [DIGIT_W-1:0] b_1;
  logic               operator;
  logic               operands_valid;
  logic [3:0]         entry_pos;
  logic               digit_err;

  modport master (
    output KEY_ENTER_N, digit_in, op_in,
    input  a_10, a_1, b_10, b_1, operator, operands_valid, entry_pos, digit_err
  );

  modport slave (
    input  KEY_ENTER_N, digit_in, op_in,
    output a_10, a_1, b_10, b_1, operator, operands_valid, entry_pos, digit_err
  );
endinterface

// File: rtl/bcd_operand_entry_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability filter, one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  logic             sync1, sync2;
  logic             filtered, filt_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed with the filtered level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtered <= 1'b1;
      cnt      <= '0;
    end else if (sync2 == filtered) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      filtered <= sync2;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered pulse on the falling edge of the filtered level only; release is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_d <= 1'b1;
      press  <= 1'b0;
    end else begin
      filt_d <= filtered;
      press  <= filt_d & ~filtered;
    end
  end
endmodule

// File: rtl/bcd_operand_entry.sv
// Operand entry front end: collects A tens/ones, B tens/ones and the operator, one digit per press.
module bcd_operand_entry
  import bcd_calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  bcd_operand_entry_if.slave  bus
);
  logic               press;
  entry_state_t       state;
  logic [DIGIT_W-1:0] a_10_q, a_1_q, b_10_q, b_1_q;
  logic               operator_q, valid_q, err_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .key_n(bus.KEY_ENTER_N),
    .press(press)
  );

  // Entry FSM and operand registers; everything moves only on a debounced press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= A_TENS;
      a_10_q     <= '0;
      a_1_q      <= '0;
      b_10_q     <= '0;
      b_1_q      <= '0;
      operator_q <= OP_ADD;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (press) begin
      if (state == DONE) begin
        // Start-over press: clears the pair but keeps the last operator, captures no digit.
        a_10_q  <= '0;
        a_1_q   <= '0;
        b_10_q  <= '0;
        b_1_q   <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        state   <= A_TENS;
      end else if (!is_bcd(bus.digit_in)) begin
        err_q <= 1'b1;
      end else begin
        err_q <= 1'b0;
        case (state)
          A_TENS: begin a_10_q <= bus.digit_in; state <= A_ONES; end
          A_ONES: begin a_1_q  <= bus.digit_in; state <= B_TENS; end
          B_TENS: begin b_10_q <= bus.digit_in; state <= B_ONES; end
          B_ONES: begin
            b_1_q      <= bus.digit_in;
            operator_q <= bus.op_in;
            valid_q    <= 1'b1;
            state      <= DONE;
          end
          default: state <= A_TENS;
        endcase
      end
    end
  end

  assign bus.a_10           = a_10_q;
  assign bus.a_1            = a_1_q;
  assign bus.b_10           = b_10_q;
  assign bus.b_1            = b_1_q;
  assign bus.operator       = operator_q;
  assign bus.operands_valid = valid_q;
  assign bus.entry_pos      = state;
  assign bus.digit_err      = err_q;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with a press-level reference model compared every cycle.
module tb_bcd_operand_entry;
  import bcd_calc_pkg::*;

  localparam int DEB = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  bcd_operand_entry_if bus();

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: button seen as a stream of samples, operands as an array indexed by position.
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_filt = 1'b1, m_prevf = 1'b1, m_press = 1'b0;
  int         m_run = 0;
  logic [3:0] m_dig [4];
  int         m_pos = 0;
  logic       m_op = 1'b0, m_err = 1'b0;

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_filt <= 1'b1; m_prevf <= 1'b1; m_press <= 1'b0;
      m_run <= 0; m_pos <= 0; m_op <= 1'b0; m_err <= 1'b0;
      for (int i = 0; i < 4; i++) m_dig[i] <= 4'd0;
    end else begin
      m_s1 <= bus.KEY_ENTER_N;
      m_s2 <= m_s1;
      if (m_s2 == m_filt) m_run <= 0;
      else if (m_run + 1 >= DEB) begin m_filt <= m_s2; m_run <= 0; end
      else m_run <= m_run + 1;
      m_prevf <= m_filt;
      m_press <= m_prevf && !m_filt;
      if (m_press) begin
        if (m_pos == 4) begin
          for (int i = 0; i < 4; i++) m_dig[i] <= 4'd0;
          m_pos <= 0;
          m_err <= 1'b0;
        end else if (bus.digit_in > 4'd9) begin
          m_err <= 1'b1;
        end else begin
          m_dig[m_pos] <= bus.digit_in;
          m_err <= 1'b0;
          m_pos <= m_pos + 1;
          if (m_pos == 3) m_op <= bus.op_in;
        end
      end
    end
  end

  function automatic logic [3:0] exp_pos(input int p);
    logic [3:0] top;
    top = 4'b1000;
    return (p < 4) ? (top >> p) : 4'b0000;
  endfunction

  // Every settled cycle outside reset, the DUT must match the model.
  always @(negedge CLOCK_50) begin
    if (RESET_N) begin
      check("cyc_a_10", bus.a_10, m_dig[0]);
      check("cyc_a_1", bus.a_1, m_dig[1]);
      check("cyc_b_10", bus.b_10, m_dig[2]);
      check("cyc_b_1", bus.b_1, m_dig[3]);
      check("cyc_operator", bus.operator, m_op);
      check("cyc_valid", bus.operands_valid, m_pos == 4);
      check("cyc_entry_pos", bus.entry_pos, exp_pos(m_pos));
      check("cyc_digit_err", bus.digit_err, m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d, input logic op);
    bus.digit_in    = d;
    bus.op_in       = op;
    bus.KEY_ENTER_N = 1'b0;
    tick(10);
    bus.KEY_ENTER_N = 1'b1;
    tick(10);
  endtask

  initial begin
    int n;
    bus.KEY_ENTER_N = 1'b1;
    bus.digit_in    = 4'd0;
    bus.op_in       = OP_ADD;
    tick(3);
    RESET_N = 1'b1;
    tick(1);

    // Reset state and idle stability
    check("rst_a_10", bus.a_10, 4'd0);
    check("rst_b_1", bus.b_1, 4'd0);
    check("rst_valid", bus.operands_valid, 1'b0);
    check("rst_entry_pos", bus.entry_pos, 4'b1000);
    check("rst_digit_err", bus.digit_err, 1'b0);
    tick(100);
    check("idle_entry_pos", bus.entry_pos, 4'b1000);
    check("idle_a_10", bus.a_10, 4'd0);

    // Full entry 47 - 25; valid must rise exactly with b_1
    press_key(4'd4, OP_SUB);
    press_key(4'd7, OP_SUB);
    press_key(4'd2, OP_SUB);
    check("b_ones_pos", bus.entry_pos, 4'b0001);
    bus.digit_in    = 4'd5;
    bus.KEY_ENTER_N = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("valid_with_b1", bus.operands_valid, bus.b_1 == 4'd5);
    end
    bus.KEY_ENTER_N = 1'b1;
    tick(10);
    check("full_a_10", bus.a_10, 4'd4);
    check("full_a_1", bus.a_1, 4'd7);
    check("full_b_10", bus.b_10, 4'd2);
    check("full_b_1", bus.b_1, 4'd5);
    check("full_operator", bus.operator, OP_SUB);
    check("full_valid", bus.operands_valid, 1'b1);
    check("full_entry_pos", bus.entry_pos, 4'b0000);

    // DONE ignores switches; next press clears and keeps operator
    for (int i = 0; i < 8; i++) begin
      bus.op_in    = i[0];
      bus.digit_in = 4'(i + 3);
      tick(3);
    end
    check("done_a_10", bus.a_10, 4'd4);
    check("done_b_1", bus.b_1, 4'd5);
    check("done_operator", bus.operator, OP_SUB);
    press_key(4'd9, OP_ADD);
    check("clr_a_10", bus.a_10, 4'd0);
    check("clr_a_1", bus.a_1, 4'd0);
    check("clr_b_10", bus.b_10, 4'd0);
    check("clr_b_1", bus.b_1, 4'd0);
    check("clr_valid", bus.operands_valid, 1'b0);
    check("clr_entry_pos", bus.entry_pos, 4'b1000);
    check("clr_operator_kept", bus.operator, OP_SUB);

    // Bounce shorter than the filter is ignored, a real hold captures once
    bus.digit_in    = 4'd8;
    bus.KEY_ENTER_N = 1'b0; tick(2);
    bus.KEY_ENTER_N = 1'b1; tick(1);
    bus.KEY_ENTER_N = 1'b0; tick(1);
    bus.KEY_ENTER_N = 1'b1; tick(15);
    check("bounce_entry_pos", bus.entry_pos, 4'b1000);
    check("bounce_a_10", bus.a_10, 4'd0);
    bus.KEY_ENTER_N = 1'b0; tick(10);
    bus.KEY_ENTER_N = 1'b1; tick(10);
    check("hold_a_10", bus.a_10, 4'd8);
    check("hold_entry_pos", bus.entry_pos, 4'b0100);

    // Non-BCD digit sets error without advancing; valid digit clears it
    press_key(4'hB, OP_ADD);
    check("bad_err", bus.digit_err, 1'b1);
    check("bad_entry_pos", bus.entry_pos, 4'b0100);
    check("bad_a_1", bus.a_1, 4'd0);
    press_key(4'd3, OP_ADD);
    check("good_a_1", bus.a_1, 4'd3);
    check("good_err", bus.digit_err, 1'b0);
    check("good_entry_pos", bus.entry_pos, 4'b0010);

    // Press-to-update latency: 2 sync + 4 filter + 1 pulse + 1 update edge
    RESET_N = 1'b0; tick(1);
    RESET_N = 1'b1; tick(1);
    bus.digit_in    = 4'd6;
    bus.KEY_ENTER_N = 1'b0;
    n = 0;
    while (n < 30 && bus.a_10 != 4'd6) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    check("latency_edges", n, 8);
    bus.KEY_ENTER_N = 1'b1;
    tick(10);
    check("lat_a_10", bus.a_10, 4'd6);
    check("lat_entry_pos", bus.entry_pos, 4'b0100);

    // Asynchronous reset between edges
    @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    check("async_a_10", bus.a_10, 4'd0);
    check("async_entry_pos", bus.entry_pos, 4'b1000);
    #1 RESET_N = 1'b1;
    tick(5);
    check("post_async_entry_pos", bus.entry_pos, 4'b1000);
    check("post_async_a_10", bus.a_10, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
